ex_stage_fwd_alu: RTL and testbench

// - Execute stage of the 5-stage RISC-V pipeline: forwarding unit, operand muxes, ALU and EX/MEM pipeline register.
// - Sits between the ID/EX register and the memory-access stage.
// - Resolves RAW hazards from EX/MEM and MEM/WB, computes the ALU result and branch target, and registers them with the control bits.

---
 rtl/ex_stage_fwd_alu.sv | 171 +++++++++++++++++
 tb/tb_ex_stage_fwd_alu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_fwd_alu.sv
// ex_stage_fwd_alu
//   Execute stage of the 5-stage RISC-V pipeline: forwarding unit, operand
//   muxes, ALU, branch-target adder and the EX/MEM pipeline register.
//
//   Build option: define EX_FORWARD_EN to enable EX/MEM and MEM/WB
//   forwarding. Without it, forward_a/forward_b stay 00, operands come only
//   from the id_ex_* inputs and the mem_wb_* ports are ignored.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   id_ex_*                      PC, register values, immediate, register
//                                indices of the instruction in EX
//   alu_ctrl, alusrc             ALU operation code, operand-B select
//   branch..regwrite             control bits carried into EX/MEM
//   mem_wb_rd/regwrite/wdata     writeback-stage destination and value
//   ex_mem_*                     registered EX results and controls
//   forward_a, forward_b         combinational forwarding selects
//                                (00 regfile, 01 MEM/WB, 10 EX/MEM)
module ex_stage_fwd_alu #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   id_ex_pc,
    input  logic [XLEN-1:0]   id_ex_rs1_data,
    input  logic [XLEN-1:0]   id_ex_rs2_data,
    input  logic [XLEN-1:0]   id_ex_imm,
    input  logic [REG_AW-1:0] id_ex_rs1,
    input  logic [REG_AW-1:0] id_ex_rs2,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic [3:0]        alu_ctrl,
    input  logic              alusrc,
    input  logic              branch,
    input  logic              memwrite,
    input  logic              memread,
    input  logic              memtoreg,
    input  logic              regwrite,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_regwrite,
    input  logic [XLEN-1:0]   mem_wb_wdata,
    output logic [XLEN-1:0]   ex_mem_pc,
    output logic              ex_mem_zero,
    output logic [XLEN-1:0]   ex_mem_alu_result,
    output logic [XLEN-1:0]   ex_mem_store_data,
    output logic [REG_AW-1:0] ex_mem_rd,
    output logic              ex_mem_branch,
    output logic              ex_mem_memwrite,
    output logic              ex_mem_memread,
    output logic              ex_mem_memtoreg,
    output logic              ex_mem_regwrite,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

`ifdef EX_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    localparam int SHW = $clog2(XLEN);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // EX/MEM register state
    logic [XLEN-1:0]   pc_q, alu_result_q, store_data_q;
    logic              zero_q;
    logic [REG_AW-1:0] rd_q;
    logic              branch_q, memwrite_q, memread_q, memtoreg_q, regwrite_q;

    logic [XLEN-1:0]   pc_d, alu_result_d;
    logic              zero_d;

    logic [XLEN-1:0]        op_a, fwd_b, op_b;
    logic signed [XLEN-1:0] op_a_s, op_b_s;
    logic [SHW-1:0]         shamt;

    // EX/MEM is checked before MEM/WB so the younger result wins; x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (FWD_EN && regwrite_q && (rd_q != '0) && (rd_q == rs))
            return FWD_MEM;
        else if (FWD_EN && mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    function automatic logic [XLEN-1:0] fwd_val(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] rf_val);
        case (sel)
            FWD_MEM: return alu_result_q;
            FWD_WB:  return mem_wb_wdata;
            default: return rf_val;
        endcase
    endfunction

    always_comb begin
        forward_a = fwd_sel(id_ex_rs1);
        forward_b = fwd_sel(id_ex_rs2);
    end

    // Forwarding is resolved before the immediate mux so stores still carry the forwarded rs2.
    always_comb begin
        op_a   = fwd_val(forward_a, id_ex_rs1_data);
        fwd_b  = fwd_val(forward_b, id_ex_rs2_data);
        op_b   = alusrc ? id_ex_imm : fwd_b;
        op_a_s = op_a;
        op_b_s = op_b;
        shamt  = op_b[SHW-1:0];
    end

    always_comb begin
        alu_result_d = '0;
        case (alu_ctrl)
            4'b0000: alu_result_d = op_a & op_b;
            4'b0001: alu_result_d = op_a | op_b;
            4'b0010: alu_result_d = op_a + op_b;
            4'b0110: alu_result_d = op_a - op_b;
            4'b0100: alu_result_d = op_a ^ op_b;
            4'b0011: alu_result_d = op_a << shamt;
            4'b0101: alu_result_d = op_a >> shamt;
            4'b1000: alu_result_d = op_a_s >>> shamt;
            4'b0111: alu_result_d = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            default: alu_result_d = '0;
        endcase
        zero_d = (alu_result_d == '0);
        pc_d   = id_ex_pc + {id_ex_imm[XLEN-2:0], 1'b0};
    end

    // EX -> EX/MEM boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= '0;
            zero_q       <= 1'b0;
            alu_result_q <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            branch_q     <= 1'b0;
            memwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            memtoreg_q   <= 1'b0;
            regwrite_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            zero_q       <= zero_d;
            alu_result_q <= alu_result_d;
            store_data_q <= fwd_b;
            rd_q         <= id_ex_rd;
            branch_q     <= branch;
            memwrite_q   <= memwrite;
            memread_q    <= memread;
            memtoreg_q   <= memtoreg;
            regwrite_q   <= regwrite;
        end
    end

    assign ex_mem_pc         = pc_q;
    assign ex_mem_zero       = zero_q;
    assign ex_mem_alu_result = alu_result_q;
    assign ex_mem_store_data = store_data_q;
    assign ex_mem_rd         = rd_q;
    assign ex_mem_branch     = branch_q;
    assign ex_mem_memwrite   = memwrite_q;
    assign ex_mem_memread    = memread_q;
    assign ex_mem_memtoreg   = memtoreg_q;
    assign ex_mem_regwrite   = regwrite_q;

endmodule

// File: tb/tb_ex_stage_fwd_alu.sv
module tb_ex_stage_fwd_alu;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

`ifdef EX_FORWARD_EN
    localparam bit M_FWD = 1'b1;
`else
    localparam bit M_FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [XLEN-1:0]   id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [REG_AW-1:0] id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [3:0]        alu_ctrl;
    logic              alusrc, branch, memwrite, memread, memtoreg, regwrite;
    logic [REG_AW-1:0] mem_wb_rd;
    logic              mem_wb_regwrite;
    logic [XLEN-1:0]   mem_wb_wdata;
    logic [XLEN-1:0]   ex_mem_pc, ex_mem_alu_result, ex_mem_store_data;
    logic              ex_mem_zero;
    logic [REG_AW-1:0] ex_mem_rd;
    logic              ex_mem_branch, ex_mem_memwrite, ex_mem_memread, ex_mem_memtoreg, ex_mem_regwrite;
    logic [1:0]        forward_a, forward_b;

    int n_checks = 0;
    int n_errors = 0;

    // model of the EX/MEM register contents
    logic [XLEN-1:0]   m_pc, m_result, m_store;
    logic              m_zero;
    logic [REG_AW-1:0] m_rd;
    logic [4:0]        m_ctl;   // {branch, memwrite, memread, memtoreg, regwrite}

    ex_stage_fwd_alu #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst),
        .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
        .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .alu_ctrl(alu_ctrl), .alusrc(alusrc),
        .branch(branch), .memwrite(memwrite), .memread(memread),
        .memtoreg(memtoreg), .regwrite(regwrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .mem_wb_wdata(mem_wb_wdata),
        .ex_mem_pc(ex_mem_pc), .ex_mem_zero(ex_mem_zero),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
        .ex_mem_rd(ex_mem_rd), .ex_mem_branch(ex_mem_branch),
        .ex_mem_memwrite(ex_mem_memwrite), .ex_mem_memread(ex_mem_memread),
        .ex_mem_memtoreg(ex_mem_memtoreg), .ex_mem_regwrite(ex_mem_regwrite),
        .forward_a(forward_a), .forward_b(forward_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference ALU from the operation table: wrap-around arithmetic, 6-bit shift amount.
    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        int sh;
        longint sa;
        sh = int'(b[5:0]);
        sa = longint'(a);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd6: return a - b;
            4'd4: return a ^ b;
            4'd3: return a << sh;
            4'd5: return a >> sh;
            4'd8: return XLEN'(sa >>> sh);
            4'd7: return (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] ref_sel(input logic [REG_AW-1:0] rs);
        if (!M_FWD || rs == 0) return 2'b00;
        if (m_ctl[0] && m_rd == rs) return 2'b10;
        if (mem_wb_regwrite && mem_wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [XLEN-1:0] ref_val(input logic [1:0] s, input logic [XLEN-1:0] rf);
        if (s == 2'b10) return m_result;
        if (s == 2'b01) return mem_wb_wdata;
        return rf;
    endfunction

    task automatic model_clear();
        m_pc = '0; m_result = '0; m_store = '0; m_zero = 1'b0; m_rd = '0; m_ctl = '0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".pc"},    ex_mem_pc, m_pc);
        check({tag, ".zero"},  XLEN'(ex_mem_zero), XLEN'(m_zero));
        check({tag, ".res"},   ex_mem_alu_result, m_result);
        check({tag, ".store"}, ex_mem_store_data, m_store);
        check({tag, ".rd"},    XLEN'(ex_mem_rd), XLEN'(m_rd));
        check({tag, ".ctl"},   XLEN'({ex_mem_branch, ex_mem_memwrite, ex_mem_memread,
                                       ex_mem_memtoreg, ex_mem_regwrite}), XLEN'(m_ctl));
    endtask

    task automatic clr_in();
        id_ex_pc = '0; id_ex_rs1_data = '0; id_ex_rs2_data = '0; id_ex_imm = '0;
        id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0; alu_ctrl = '0; alusrc = 1'b0;
        branch = 0; memwrite = 0; memread = 0; memtoreg = 0; regwrite = 0;
        mem_wb_rd = '0; mem_wb_regwrite = 1'b0; mem_wb_wdata = '0;
    endtask

    // Inputs are already set; checks forwarding selects, clocks once, checks EX/MEM.
    task automatic step(input string tag);
        logic [1:0]      sa, sb;
        logic [XLEN-1:0] a, fb, b, r;
        #1;
        sa = ref_sel(id_ex_rs1);
        sb = ref_sel(id_ex_rs2);
        check({tag, ".fwd_a"}, XLEN'(forward_a), XLEN'(sa));
        check({tag, ".fwd_b"}, XLEN'(forward_b), XLEN'(sb));
        a  = ref_val(sa, id_ex_rs1_data);
        fb = ref_val(sb, id_ex_rs2_data);
        b  = alusrc ? id_ex_imm : fb;
        r  = ref_alu(alu_ctrl, a, b);
        @(posedge clk);
        #1;
        m_pc     = id_ex_pc + id_ex_imm * 2;
        m_result = r;
        m_zero   = (r == 0);
        m_store  = fb;
        m_rd     = id_ex_rd;
        m_ctl    = {branch, memwrite, memread, memtoreg, regwrite};
        check_regs(tag);
    endtask

    function automatic logic [XLEN-1:0] rnd_data();
        case ($urandom_range(0, 3))
            0: return XLEN'($urandom_range(0, 70));
            1: return '1;
            2: return {1'b1, 63'($urandom)};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    initial begin
        clr_in();
        model_clear();
        rst = 1'b1;

        // held in reset with random inputs
        for (int i = 0; i < 3; i++) begin
            id_ex_pc = rnd_data(); id_ex_imm = rnd_data(); id_ex_rs1_data = rnd_data();
            id_ex_rd = REG_AW'($urandom); {branch, memwrite, memread, memtoreg, regwrite} = 5'h1f;
            alu_ctrl = 4'd2;
            @(posedge clk);
            #1;
            check_regs("rst_hold");
        end
        clr_in();
        @(negedge clk);
        rst = 1'b0;

        // ADD 5+7
        id_ex_rs1 = 1; id_ex_rs2 = 2; id_ex_rs1_data = 5; id_ex_rs2_data = 7; alu_ctrl = 4'b0010;
        step("add");
        check("add_const", ex_mem_alu_result, 64'd12);
        check("add_zero", XLEN'(ex_mem_zero), 0);

        // SUB 9-9
        id_ex_rs1_data = 9; id_ex_rs2_data = 9; alu_ctrl = 4'b0110;
        step("sub");
        check("sub_zero", XLEN'(ex_mem_zero), 1);

        // SLL 1<<63
        id_ex_rs1_data = 1; id_ex_rs2_data = 63; alu_ctrl = 4'b0011;
        step("sll");
        check("sll_const", ex_mem_alu_result, 64'h8000_0000_0000_0000);

        // SRA 0x8000.. by 63
        id_ex_rs1_data = 64'h8000_0000_0000_0000; alu_ctrl = 4'b1000;
        step("sra");
        check("sra_const", ex_mem_alu_result, '1);

        // SLT -1 < 1
        id_ex_rs1_data = '1; id_ex_rs2_data = 1; alu_ctrl = 4'b0111;
        step("slt");
        check("slt_const", ex_mem_alu_result, 64'd1);

        // producer of x5 = 0x10, then consumer with both hazards pending
        clr_in();
        id_ex_rd = 5; regwrite = 1; alusrc = 1; id_ex_imm = 64'h10; alu_ctrl = 4'b0010;
        step("prod_x5");
        clr_in();
        id_ex_rs1 = 5; id_ex_rs1_data = 64'h99; alu_ctrl = 4'b0010; alusrc = 1;
        mem_wb_rd = 5; mem_wb_regwrite = 1; mem_wb_wdata = 64'h20;
        step("prio");
        check("prio_opa", ex_mem_alu_result, M_FWD ? 64'h10 : 64'h99);

        // x0 never forwarded
        clr_in();
        id_ex_rd = 0; regwrite = 1; alu_ctrl = 4'b0010; alusrc = 1; id_ex_imm = 64'h77;
        step("prod_x0");
        clr_in();
        id_ex_rs2 = 0; id_ex_rs2_data = 64'h33; alu_ctrl = 4'b0001;
        step("x0");
        check("x0_res", ex_mem_alu_result, 64'h33);

        // store with immediate B and rs2 forwarded from MEM/WB
        clr_in();
        id_ex_rs2 = 6; id_ex_rs2_data = 64'h11; alusrc = 1; id_ex_imm = 8; alu_ctrl = 4'b0010;
        memwrite = 1; mem_wb_rd = 6; mem_wb_regwrite = 1; mem_wb_wdata = 64'hAB;
        step("store");
        check("store_b", ex_mem_alu_result, 64'd8);
        check("store_data", ex_mem_store_data, M_FWD ? 64'hAB : 64'h11);

        // branch target
        clr_in();
        id_ex_pc = 64'h40; id_ex_imm = 4; branch = 1;
        step("br");
        check("br_pc", ex_mem_pc, 64'h48);
        check("br_ctl", XLEN'({ex_mem_branch, ex_mem_memread}), XLEN'(2'b10));

        // async reset pulse between edges
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_regs("rst_pulse");
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            id_ex_pc = rnd_data(); id_ex_imm = rnd_data();
            id_ex_rs1_data = rnd_data(); id_ex_rs2_data = rnd_data();
            id_ex_rs1 = REG_AW'($urandom_range(0, 7));
            id_ex_rs2 = REG_AW'($urandom_range(0, 7));
            id_ex_rd  = REG_AW'($urandom_range(0, 7));
            alu_ctrl  = 4'($urandom_range(0, 15));
            alusrc    = 1'($urandom);
            {branch, memwrite, memread, memtoreg, regwrite} = 5'($urandom);
            mem_wb_rd = REG_AW'($urandom_range(0, 7));
            mem_wb_regwrite = 1'($urandom);
            mem_wb_wdata = rnd_data();
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
